aes_result_unloader: RTL and testbench
======================================

// Module: aes_result_unloader
// PURPOSE
//  Downstream of the AES controller/core pair. Captures the 128-bit core state on each
//  controller done pulse and buffers up to DEPTH blocks in a small FIFO.
//  Streams each block out as WORD_W-bit words over a valid/ready interface, most
//  significant word first. The controller has no backpressure: writes into a full
//  buffer are dropped and flagged.
// PARAMETERS
//  DATA_W  128  block width; must equal the core state width
//  WORD_W  32   output word width; DATA_W % WORD_W == 0; NWORDS = DATA_W/WORD_W
//  DEPTH   2    FIFO depth in blocks; power of 2, >= 2
// PORTS
//  clk        in   1               clock, all logic on rising edge
//  rst        in   1               synchronous reset, active-high
//  done       in   1               controller round-10 completion pulse, one cycle
//  state_in   in   DATA_W          core state (ciphertext), valid when done=1
//  out_ready  in   1               consumer can accept out_data this cycle
//  out_valid  out  1               out_data holds a valid word
//  out_data   out  WORD_W          current word
//  out_last   out  1               current word is the final word of its block
//  fill       out  clog2(DEPTH)+1  number of blocks held, including the one streaming
//  overflow   out  1               sticky: a done arrived while the FIFO was full
// BEHAVIOUR
//  Reset (rst=1 at clk edge):
//   - out_valid=0, out_data=0, out_last=0, fill=0, overflow=0.
//   - wr/rd pointers = 0, word index = 0. FIFO contents are don't-care.
//   - rst has priority over every other input, including mid-block: a partially
//     streamed block is discarded.
//  Push:
//   - done=1 and (fill<DEPTH or pop this cycle): write state_in at wr_ptr, wr_ptr++.
//     Pointers wrap modulo DEPTH.
//   - done=1, fill==DEPTH and no pop this cycle: data dropped, overflow<=1.
//     overflow clears only on rst.
//  Stream:
//   - Transfer = out_valid & out_ready.
//   - out_valid = (fill != 0); out_valid is a combinational function of registered fill.
//   - out_data = slice of head block. Word index k=0..NWORDS-1 selects
//     bits [DATA_W-1-k*WORD_W -: WORD_W].
//   - out_last = out_valid & (k == NWORDS-1).
//   - Transfer with k<NWORDS-1: k++.
//   - Transfer with k==NWORDS-1: k<=0, rd_ptr++ (pop), fill--.
//   - out_valid=1 and out_ready=0: out_data/out_last held stable (AXI-stream rule).
//     out_valid never drops without a transfer.
//  Simultaneous push and pop:
//   - fill unchanged; both pointers advance.
//   - Push is accepted even when fill==DEPTH; overflow is not set.
//  Latency:
//   - done at edge N (FIFO empty) -> out_valid=1 with word 0 after edge N, i.e. in
//     cycle N+1. No combinational path from done/state_in to any output.
//   - With out_ready held 1, one block drains in NWORDS cycles; back-to-back blocks
//     have no bubble.
//  fill width is clog2(DEPTH)+1 so that fill==DEPTH is representable.
//  Implementation: registered pointers, fill and word index; output mux is
//  combinational from FIFO storage.
// TESTING
//  1. Reset: assert rst 2 cycles with done=1 -> out_valid=0, fill=0, overflow=0 after
//     release.
//  2. Single block, out_ready=1: state_in=128'h3925841d02dc09fbdc118597196a0b32 with
//     done -> next 4 cycles out_data = 3925841d, 02dc09fb, dc118597, 196a0b32;
//     out_last only on the 4th word; then out_valid=0.
//  3. Backpressure: same block, out_ready toggles 1,0,0,1,1,0,1 -> words are emitted
//     only on ready=1 cycles, data stable while stalled, fill=1 until the final
//     transfer.
//  4. Overflow: out_ready=0, three done pulses (blocks A,B,C) -> fill=2, overflow=1.
//     Then out_ready=1 -> only A then B are streamed (8 words); C never appears.
//  5. Push+pop at full: fill=2, last word of A transferred in the same cycle as
//     done(C) -> fill stays 2, overflow=0; output order is B, then C.
//  6. Mid-block reset: after 2 words of A, pulse rst -> out_valid=0, fill=0.
//     A following done(D) streams D starting at word 0.

Source files
------------

// File: rtl/aes_result_unloader.sv
// AES result unloader: captures the core state on each controller done pulse
// into a small block FIFO and streams every block out as words over
// valid/ready, most significant word first. The controller cannot be stalled,
// so a done that finds the FIFO full (with no pop in the same cycle) is
// dropped and recorded in a sticky overflow flag.
module aes_result_unloader #(
   parameter int DATA_W = 128,
   parameter int WORD_W = 32,
   parameter int DEPTH  = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    done,
   input  logic [DATA_W-1:0]       state_in,
   input  logic                    out_ready,
   output logic                    out_valid,
   output logic [WORD_W-1:0]       out_data,
   output logic                    out_last,
   output logic [$clog2(DEPTH):0]  fill,
   output logic                    overflow
);

   localparam int NWORDS = DATA_W / WORD_W;
   localparam int AW     = $clog2(DEPTH);
   localparam int KW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam int FW     = AW + 1;
   localparam logic [KW-1:0] K_LAST    = KW'(NWORDS - 1);
   localparam logic [FW-1:0] FILL_FULL = FW'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [KW-1:0]     word_idx;
   logic [DATA_W-1:0] head;
   logic [WORD_W-1:0] words [NWORDS];
   logic              xfer;
   logic              pop;
   logic              push;

   // Handshake decode; a push into a full FIFO is legal when the head pops in the same cycle.
   always_comb begin
      out_valid = (fill != '0);
      xfer      = out_valid & out_ready;
      pop       = xfer & (word_idx == K_LAST);
      push      = done & ((fill != FILL_FULL) | pop);
   end

   // Output word mux straight from FIFO storage; word 0 is the top slice of the block.
   always_comb begin
      head = mem[rd_ptr];
      for (int i = 0; i < NWORDS; i++) begin
         words[i] = head[DATA_W-1-i*WORD_W -: WORD_W];
      end
      out_data = out_valid ? words[word_idx] : '0;
      out_last = out_valid & (word_idx == K_LAST);
   end

   // Block storage; contents need no reset since pointers and fill define validity.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem[wr_ptr] <= state_in;
      end
   end

   // Pointers, occupancy, word index and sticky overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         word_idx <= '0;
         fill     <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (xfer) begin
            word_idx <= pop ? '0 : word_idx + KW'(1);
         end
         case ({push, pop})
            2'b10:   fill <= fill + FW'(1);
            2'b01:   fill <= fill - FW'(1);
            default: fill <= fill;
         endcase
         if (done && !push) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_aes_result_unloader.sv
// Bench for aes_result_unloader: a queue-of-blocks reference model checked
// against the DUT on every cycle, directed scenarios pinned with literal
// expectations, then a randomized phase.
module tb_aes_result_unloader;

   localparam int DATA_W = 128;
   localparam int WORD_W = 32;
   localparam int DEPTH  = 2;
   localparam int NW     = DATA_W / WORD_W;

   logic              clk = 1'b0;
   logic              rst;
   logic              done;
   logic [DATA_W-1:0] state_in;
   logic              out_ready;
   logic              out_valid;
   logic [WORD_W-1:0] out_data;
   logic              out_last;
   logic [1:0]        fill;
   logic              overflow;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 0;

   logic [DATA_W-1:0] mq[$];
   int                mk   = 0;
   bit                movf = 0;

   logic [DATA_W-1:0] blk_ref = 128'h3925841d02dc09fbdc118597196a0b32;
   logic [31:0]       exp2 [4] = '{32'h3925841d, 32'h02dc09fb, 32'hdc118597, 32'h196a0b32};
   int                rseq [7] = '{1, 0, 0, 1, 1, 0, 1};

   aes_result_unloader #(.DATA_W(DATA_W), .WORD_W(WORD_W), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .done      (done),
      .state_in  (state_in),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .fill      (fill),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word_of(input logic [127:0] b, input int k);
      return b[127-32*k -: 32];
   endfunction

   function automatic logic [127:0] rand_blk();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a queue of whole blocks plus the index of the word on show.
   always @(posedge clk) begin
      if (rst) begin
         mq.delete();
         mk   = 0;
         movf = 0;
      end else begin
         automatic bit had   = (mq.size() != 0);
         automatic bit popm  = had && out_ready && (mk == NW - 1);
         automatic bit fullm = (mq.size() == DEPTH);
         if (had && out_ready) begin
            if (mk == NW - 1) begin
               mk = 0;
               void'(mq.pop_front());
            end else begin
               mk++;
            end
         end
         if (done) begin
            if (!fullm || popm) mq.push_back(state_in);
            else movf = 1;
         end
      end
   end

   // Per-cycle comparison of DUT outputs against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         automatic bit ev = (mq.size() != 0);
         check("out_valid", out_valid, ev);
         check("fill", fill, mq.size());
         check("overflow", overflow, movf);
         if (ev) begin
            check("out_data", out_data, word_of(mq[0], mk));
            check("out_last", out_last, mk == NW - 1);
         end
      end
   end

   initial begin
      logic [127:0] a, b, c, d;
      int ones;
      rst = 1'b1; done = 1'b1; state_in = rand_blk(); out_ready = 1'b0;

      // Reset held two cycles with done asserted.
      repeat (2) @(negedge clk);
      rst = 1'b0; done = 1'b0; chk_en = 1;
      check("rst_valid", out_valid, 0);
      check("rst_fill", fill, 0);
      check("rst_ovf", overflow, 0);
      check("rst_data", out_data, 0);
      check("rst_last", out_last, 0);

      // Single block with ready held high.
      out_ready = 1'b1; state_in = blk_ref; done = 1'b1;
      @(negedge clk); done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("t2_word", out_data, exp2[i]);
         check("t2_last", out_last, i == 3);
         @(negedge clk);
      end
      check("t2_idle", out_valid, 0);

      // Backpressure pattern.
      out_ready = 1'b0; done = 1'b1;
      @(negedge clk); done = 1'b0;
      ones = 0;
      for (int i = 0; i < 7; i++) begin
         check("t3_fill", fill, 1);
         check("t3_word", out_data, exp2[ones]);
         out_ready = rseq[i][0];
         ones += rseq[i];
         @(negedge clk);
      end
      check("t3_idle", out_valid, 0);
      check("t3_fill_end", fill, 0);

      // Overflow: three dones into a two-deep FIFO while stalled.
      a = rand_blk(); b = rand_blk(); c = rand_blk();
      out_ready = 1'b0;
      done = 1'b1; state_in = a; @(negedge clk);
      state_in = b; @(negedge clk);
      state_in = c; @(negedge clk);
      done = 1'b0;
      check("t4_fill", fill, 2);
      check("t4_ovf", overflow, 1);
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check("t4_word", out_data, word_of(i < 4 ? a : b, i % 4));
         @(negedge clk);
      end
      check("t4_idle", out_valid, 0);
      check("t4_ovf_sticky", overflow, 1);

      // Push and pop in the same cycle at full.
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      check("t5_ovf_clr", overflow, 0);
      a = rand_blk(); b = rand_blk(); c = rand_blk();
      out_ready = 1'b0;
      done = 1'b1; state_in = a; @(negedge clk);
      state_in = b; @(negedge clk);
      done = 1'b0; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("t5_last", out_last, 1);
      check("t5_fill_pre", fill, 2);
      done = 1'b1; state_in = c;
      @(negedge clk); done = 1'b0;
      check("t5_fill", fill, 2);
      check("t5_ovf", overflow, 0);
      for (int i = 0; i < 8; i++) begin
         check("t5_word", out_data, word_of(i < 4 ? b : c, i % 4));
         @(negedge clk);
      end
      check("t5_idle", out_valid, 0);

      // Mid-block reset discards the partial block.
      a = rand_blk(); d = rand_blk();
      out_ready = 1'b1; done = 1'b1; state_in = a;
      @(negedge clk); done = 1'b0;
      repeat (2) @(negedge clk);
      check("t6_pre_word", out_data, word_of(a, 2));
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      check("t6_valid", out_valid, 0);
      check("t6_fill", fill, 0);
      done = 1'b1; state_in = d;
      @(negedge clk); done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("t6_word", out_data, word_of(d, i));
         @(negedge clk);
      end
      check("t6_idle", out_valid, 0);

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         done      = ($urandom_range(0, 99) < 35);
         state_in  = rand_blk();
         out_ready = ($urandom_range(0, 99) < 60);
         rst       = ($urandom_range(0, 199) == 0);
         @(negedge clk);
      end
      rst = 1'b0; done = 1'b0; out_ready = 1'b1;
      repeat (12) @(negedge clk);
      check("final_idle", out_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
